// File: rtl/dom_shared_mul_gf2n_stream.sv
// DOM multiplier over GF(2^N) for any share count, wrapped in a valid/ready pipeline.
// Fresh masks are taken through a separate randomness handshake, and a stalled stage holds its terms.

module gf2_mul #(
  parameter int N = 4
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] p_o
);

  // Low-order bits of the reduction polynomial; the x^N term is implicit.
  function automatic logic [31:0] red_poly(input int n);
    case (n)
      2:       return 32'h0000_0003;
      3:       return 32'h0000_0003;
      4:       return 32'h0000_0003;
      5:       return 32'h0000_0005;
      6:       return 32'h0000_0003;
      7:       return 32'h0000_0003;
      8:       return 32'h0000_001B;
      16:      return 32'h0000_002B;
      default: return 32'h0000_0003;
    endcase
  endfunction

  localparam logic [31:0]  RED_FULL = red_poly(N);
  localparam logic [N-1:0] RED      = RED_FULL[N-1:0];

  logic [N-1:0] acc;
  logic [N-1:0] sh;

  always_comb begin
    acc = '0;
    sh  = a_i;
    for (int i = 0; i < N; i++) begin
      if (b_i[i]) acc = acc ^ sh;
      sh = {sh[N-2:0], 1'b0} ^ (sh[N-1] ? RED : '0);
    end
    p_o = acc;
  end

endmodule

module dom_shared_mul_gf2n_stream #(
  parameter int N         = 4,
  parameter int SHARES    = 2,
  parameter int PIPELINED = 1,
  parameter int CNT_W     = 16
) (
  input  logic                                ClkxCI,
  input  logic                                RstxBI,
  input  logic                                InValidxSI,
  output logic                                InReadyxSO,
  input  logic [N*SHARES-1:0]                 _XxDI,
  input  logic [N*SHARES-1:0]                 _YxDI,
  input  logic                                RndValidxSI,
  output logic                                RndAckxSO,
  input  logic [N*SHARES*(SHARES-1)/2-1:0]    _ZxDI,
  output logic                                OutValidxSO,
  input  logic                                OutReadyxSI,
  output logic [N*SHARES-1:0]                 _QxDO,
  output logic [CNT_W-1:0]                    StarveCntxDO
);

  localparam int NPAIR = SHARES * (SHARES - 1) / 2;

  logic [N-1:0] x_sh  [SHARES];
  logic [N-1:0] y_sh  [SHARES];
  logic [N-1:0] z_w   [NPAIR];
  logic [N-1:0] prod  [SHARES][SHARES];
  logic [N-1:0] zmask [SHARES][SHARES];

  // term_q[i][i] is the inner product, term_q[i][j] (i!=j) the masked cross product.
  logic [N-1:0] term_q [SHARES][SHARES];
  logic [N-1:0] term_d [SHARES][SHARES];
  logic [N-1:0] q_int  [SHARES];

  logic             v1_q, v1_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             s1_free;
  logic             s1_adv;
  logic             fire;

  genvar gi, gj;
  generate
    for (gi = 0; gi < SHARES; gi++) begin : g_unpack
      assign x_sh[gi] = _XxDI[gi*N +: N];
      assign y_sh[gi] = _YxDI[gi*N +: N];
    end
    for (gi = 0; gi < NPAIR; gi++) begin : g_zunpack
      assign z_w[gi] = _ZxDI[gi*N +: N];
    end
    for (gi = 0; gi < SHARES; gi++) begin : g_row
      for (gj = 0; gj < SHARES; gj++) begin : g_col
        gf2_mul #(.N(N)) u_mul (
          .a_i (x_sh[gi]),
          .b_i (y_sh[gj]),
          .p_o (prod[gi][gj])
        );
        if (gi == gj) begin : g_inner
          assign zmask[gi][gj] = '0;
        end else begin : g_cross
          localparam int LO = (gi < gj) ? gi : gj;
          localparam int HI = (gi < gj) ? gj : gi;
          localparam int K  = LO * SHARES - LO * (LO + 1) / 2 + (HI - LO - 1);
          assign zmask[gi][gj] = z_w[K];
        end
      end
    end
  endgenerate

  assign s1_adv     = !v1_q || s1_free;
  assign InReadyxSO = s1_adv;
  assign fire       = InValidxSI && RndValidxSI && s1_adv;
  assign RndAckxSO  = fire;

  always_comb begin
    v1_d = v1_q;
    if (s1_adv) v1_d = fire;
    for (int i = 0; i < SHARES; i++) begin
      for (int j = 0; j < SHARES; j++) begin
        term_d[i][j] = term_q[i][j];
        if (fire) term_d[i][j] = prod[i][j] ^ zmask[i][j];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < SHARES; i++) begin
      q_int[i] = '0;
      for (int j = 0; j < SHARES; j++) begin
        q_int[i] = q_int[i] ^ term_q[i][j];
      end
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (InValidxSI && !RndValidxSI && (starve_q != {CNT_W{1'b1}})) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      v1_q     <= 1'b0;
      starve_q <= '0;
      for (int i = 0; i < SHARES; i++) begin
        for (int j = 0; j < SHARES; j++) begin
          term_q[i][j] <= '0;
        end
      end
    end else begin
      v1_q     <= v1_d;
      starve_q <= starve_d;
      for (int i = 0; i < SHARES; i++) begin
        for (int j = 0; j < SHARES; j++) begin
          term_q[i][j] <= term_d[i][j];
        end
      end
    end
  end

  assign StarveCntxDO = starve_q;

  generate
    if (PIPELINED != 0) begin : g_pipe
      logic         v2_q, v2_d;
      logic         s2_adv;
      logic [N-1:0] qr_q [SHARES];
      logic [N-1:0] qr_d [SHARES];

      assign s2_adv  = !v2_q || OutReadyxSI;
      assign s1_free = s2_adv;

      always_comb begin
        v2_d = v2_q;
        for (int i = 0; i < SHARES; i++) qr_d[i] = qr_q[i];
        if (s2_adv) begin
          v2_d = v1_q;
          if (v1_q) begin
            for (int i = 0; i < SHARES; i++) qr_d[i] = q_int[i];
          end
        end
      end

      always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
          v2_q <= 1'b0;
          for (int i = 0; i < SHARES; i++) qr_q[i] <= '0;
        end else begin
          v2_q <= v2_d;
          for (int i = 0; i < SHARES; i++) qr_q[i] <= qr_d[i];
        end
      end

      assign OutValidxSO = v2_q;
      for (gi = 0; gi < SHARES; gi++) begin : g_qpack
        assign _QxDO[gi*N +: N] = qr_q[gi];
      end
    end else begin : g_comb
      assign s1_free     = OutReadyxSI;
      assign OutValidxSO = v1_q;
      for (gi = 0; gi < SHARES; gi++) begin : g_qpack
        assign _QxDO[gi*N +: N] = q_int[gi];
      end
    end
  endgenerate

endmodule

// File: doc/dom_shared_mul_gf2n_stream.md
# dom_shared_mul_gf2n_stream

Parametrised domain-oriented-masking (DOM) multiplier over GF(2^N) for any share count. It wraps the resharing and integration registers in a valid/ready pipeline with an explicit fresh-randomness handshake. It generalises the fixed GF(4) shared multiplier used inside the masked AES S-box so that the S-box datapath can stall without recomputing or re-consuming masks. It sits between the masked inversion stages and any buffering or back-pressuring consumer.

## Interface

Parameters:

- N, 4, field width in bits; multiplication is the codebase `gf2_mul #(.N(N))`.
- SHARES, 2, number of Boolean shares (≥2).
- PIPELINED, 1, 1: Q is registered (integration stage), 0: Q is combinational from the resharing registers.
- CNT_W, 16, width of the randomness-starvation counter.

Ports:

- ClkxCI  in  1  clock; all registers update on the rising edge.
- RstxBI  in  1  asynchronous, active-low reset.
- InValidxSI  in  1  operand valid.
- InReadyxSO  out  1  block can accept operands this cycle.
- _XxDI  in  N*SHARES  shares of X; share i at [i*N +: N].
- _YxDI  in  N*SHARES  shares of Y, same packing.
- RndValidxSI  in  1  fresh randomness valid.
- RndAckxSO  out  1  randomness consumed this cycle.
- _ZxDI  in  N*SHARES*(SHARES-1)/2  fresh masks; pair word k at [k*N +: N].
- OutValidxSO  out  1  result valid.
- OutReadyxSI  in  1  consumer accepts the result.
- _QxDO  out  N*SHARES  shares of Q = X·Y, same packing.
- StarveCntxDO  out  CNT_W  saturating count of cycles where InValidxSI=1 and RndValidxSI=0.

## Operation

- Pair index k enumerates (i,j), i<j, lexicographically: (0,1)=0, (0,2)=1, …, (1,2)=SHARES-1, …
- Accept (fire) = InValidxSI & RndValidxSI & InReadyxSO. RndAckxSO = fire. No operand or mask is consumed otherwise.
- Resharing stage S1, loaded on fire:
  - inner term I_i = x_i·y_i.
  - cross terms C_ij = x_i·y_j ⊕ Z_k, and C_ji = x_j·y_i ⊕ Z_k.
  - Every term is registered individually. No XOR across domains happens before these registers.
- Integration: q_i = I_i ⊕ XOR over j≠i of C_ij. With PIPELINED=1 this is registered in stage S2; with PIPELINED=0 it is combinational from S1.
- Correctness: the XOR of all q_i equals gf2_mul(XOR x_i, XOR y_i).
- Hold rule: a stalled stage keeps its registers unchanged. A term is never recomputed with new Z, and a Z word is never reused.
- Flow control, PIPELINED=1:
  - S2 advances when !V2 | OutReadyxSI.
  - S1 advances when !V1 | S2-advance.
  - InReadyxSO = S1-advance.
- Flow control, PIPELINED=0:
  - InReadyxSO = !V1 | OutReadyxSI.
- OutValidxSO = V2 when PIPELINED=1, V1 when PIPELINED=0.
- StarveCntxDO increments by 1 in each starvation cycle, regardless of InReadyxSO, and saturates at 2^CNT_W−1.

## Timing

- Reset (asynchronous, any time, including mid-operation):
  - all term and Q registers = 0, V1 = V2 = 0, StarveCntxDO = 0.
  - OutValidxSO = 0, _QxDO = 0.
  - InReadyxSO = 1 and RndAckxSO = 0 while reset is deasserted and idle.
  - In-flight results are discarded, not delivered.
- Latency from fire to OutValidxSO: 2 cycles with PIPELINED=1, 1 cycle with PIPELINED=0.
- Throughput is 1 result per cycle while OutReadyxSI=1 and RndValidxSI=1.
- InReadyxSO is combinational from OutReadyxSI and internal valid bits. It does not depend on InValidxSI or RndValidxSI.
- While OutValidxSO=1 and OutReadyxSI=0, _QxDO is stable.
- Simultaneous output pop and input fire on a full pipeline: both occur in the same cycle with no bubble.
- RndValidxSI dropping while InValidxSI=1: no fire that cycle, and the operands must be held by the producer.

## Test plan

- Reset values: assert RstxBI=0 mid-stream with V1=V2=1 -> next cycle OutValidxSO=0, _QxDO=0, StarveCntxDO=0, InReadyxSO=1; the discarded result never appears.
- N=4, SHARES=2, PIPELINED=1, single operation with x0=4'h3, x1=4'h3 (X=0), y0=4'h5, y1=4'hC, Z=4'hA -> OutValidxSO=1 exactly 2 cycles after fire, q0 = g(3,5)⊕g(3,C)⊕A, q1 = g(3,C)⊕g(3,5)⊕A, q0⊕q1=4'h0 (g = gf2_mul).
- Randomized back-to-back stream, 1000 operands, OutReadyxSI=1 -> one result per cycle, in order, XOR of q shares equals gf2_mul(X,Y) for every operand, RndAckxSO count equals 1000.
- Back-pressure: OutReadyxSI=0 for 5 cycles with a full pipeline -> InReadyxSO=0, _QxDO and all registers frozen, no RndAckxSO; on release the results drain unchanged.
- Starvation: InValidxSI=1, RndValidxSI=0 for 7 cycles -> no fire, StarveCntxDO=7. With CNT_W=3 and 9 such cycles, the counter saturates at 7.
- SHARES=3, N=8, PIPELINED=0 -> 3 Z words consumed per fire, latency 1 cycle, share XOR equals gf2_mul(X,Y) over 500 random vectors.
